divu_seq: RTL

- Sequential unsigned 32/32 divider for the CPU execute stage; the inverse operation of the combinational unsigned multiplier.
- Restoring algorithm, one quotient bit per clock.
- Start/busy/done handshake so the pipeline can stall while the divide runs.
- Results feed the LO/HI write path: quotient to LO, remainder to HI.

---
 rtl/divu_seq.sv | 119 +++++++++++
 1 files changed

// File: rtl/divu_seq.sv
// Sequential unsigned WIDTH/WIDTH restoring divider, one quotient bit per clock.
// Optional fast divide-by-zero path with dz flag: define DIVU_DIVZERO_FAST_EN.
module divu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
`ifdef DIVU_DIVZERO_FAST_EN
    output logic             dz,
`endif
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DZ   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] qsh, dsr;
    logic [WIDTH:0]   rem;
    logic [CW-1:0]    cnt;

    logic             accept, last;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic             borrow;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] qsh_nxt;

    assign accept = (state == IDLE) && start;
    assign last   = (cnt == CW'(WIDTH-1));
    assign busy   = (state != IDLE);

    // Trial subtract one bit wider than the partial remainder; its MSB is the borrow.
    always_comb begin
        rem_sh  = {rem[WIDTH-1:0], qsh[WIDTH-1]};
        diff    = {1'b0, rem_sh} - {2'b00, dsr};
        borrow  = diff[WIDTH+1];
        rem_nxt = borrow ? rem_sh : diff[WIDTH:0];
        qsh_nxt = {qsh[WIDTH-2:0], ~borrow};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef DIVU_DIVZERO_FAST_EN
                    state_nxt = (divisor == '0) ? DZ : RUN;
`else
                    state_nxt = RUN;
`endif
                end
            end
            RUN:     if (last) state_nxt = IDLE;
            DZ:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qsh  <= '0;
            dsr  <= '0;
            rem  <= '0;
            cnt  <= '0;
            q    <= '0;
            r    <= '0;
            done <= 1'b0;
`ifdef DIVU_DIVZERO_FAST_EN
            dz   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                qsh <= dividend;
                dsr <= divisor;
                rem <= '0;
                cnt <= '0;
`ifdef DIVU_DIVZERO_FAST_EN
                if (divisor != '0) dz <= 1'b0;
`endif
            end else if (state == RUN) begin
                qsh <= qsh_nxt;
                rem <= rem_nxt;
                cnt <= cnt + CW'(1);
                if (last) begin
                    q    <= qsh_nxt;
                    r    <= rem_nxt[WIDTH-1:0];
                    done <= 1'b1;
                end
`ifdef DIVU_DIVZERO_FAST_EN
            end else if (state == DZ) begin
                // qsh still holds the captured dividend
                q    <= '1;
                r    <= qsh;
                done <= 1'b1;
                dz   <= 1'b1;
`endif
            end
        end
    end

endmodule
